regs_bist: RTL and testbench

Built-in self-test engine that acts as the initiator on the register-file port: it drives the write port (`L_S`, `Wt_addr`, `Wt_data`) and both read ports (`R_addr_A`, `R_addr_B`), checks returned `rdata_A`/`rdata_B`, and reports pass/fail. It sits beside `Regs` and takes over its ports through a top-level mux while `busy` is high. One run is four 32-cycle phases (pattern write, pattern read, address write, address read), completing in 128 cycles.

---
 rtl/regs_bist.sv | 152 +++++++++++++++
 tb/tb_regs_bist.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regs_bist.sv
// Register-file BIST initiator: writes two patterns through the write port,
// reads each back on both read ports and reports the mismatch count and the first failure.
module regs_bist #(
    parameter logic [31:0] SEED     = 32'hA5A5A5A5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] rdata_A,
    input  logic [31:0] rdata_B,
    output logic        L_S,
    output logic [4:0]  Wt_addr,
    output logic [31:0] Wt_data,
    output logic [4:0]  R_addr_A,
    output logic [4:0]  R_addr_B,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [4:0]  fail_addr,
    output logic        fail_port
);

    typedef enum logic [2:0] {IDLE, WR1, RD1, WR2, RD2, FIN} state_t;

    state_t      state, state_next;
    logic [4:0]  idx, idx_next;
    logic        in_read;
    logic [4:0]  addr_b;
    logic [31:0] exp_a, exp_b;
    logic        miss_a, miss_b;
    logic [7:0]  err_incr, err_next;

    function automatic logic [31:0] expected_data(input logic rd1, input logic [4:0] a);
        if (ZERO_REG && (a == 5'd0))
            return 32'h0;
        else if (rd1)
            return a[0] ? SEED : ~SEED;
        else
            return {27'b0, a};
    endfunction

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WR1;
                    idx_next   = 5'd0;
                end
            end
            WR1, RD1, WR2, RD2: begin
                idx_next = idx + 5'd1;
                if (idx == 5'd31) begin
                    case (state)
                        WR1:     state_next = RD1;
                        RD1:     state_next = WR2;
                        WR2:     state_next = RD2;
                        default: state_next = FIN;
                    endcase
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // 31-i on five bits is the bitwise complement of i
    always_comb begin
        in_read  = (state == RD1) || (state == RD2);
        addr_b   = (state == RD1) ? ~idx : idx;
        exp_a    = expected_data(state == RD1, idx);
        exp_b    = expected_data(state == RD1, addr_b);
        miss_a   = in_read && (rdata_A != exp_a);
        miss_b   = in_read && (rdata_B != exp_b);
        err_incr = {7'b0, miss_a} + {7'b0, miss_b};
        err_next = err_count + err_incr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 5'd0;
            L_S       <= 1'b0;
            Wt_addr   <= 5'd0;
            Wt_data   <= 32'h0;
            R_addr_A  <= 5'd0;
            R_addr_B  <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            fail_addr <= 5'd0;
            fail_port <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            busy  <= (state_next == WR1) || (state_next == RD1) ||
                     (state_next == WR2) || (state_next == RD2);
            done  <= (state_next == FIN);
            L_S   <= (state_next == WR1) || (state_next == WR2);

            // Port outputs are produced from the upcoming state so they are flop outputs
            case (state_next)
                WR1: begin
                    Wt_addr  <= idx_next;
                    Wt_data  <= idx_next[0] ? SEED : ~SEED;
                    R_addr_A <= 5'd0;
                    R_addr_B <= 5'd0;
                end
                WR2: begin
                    Wt_addr  <= idx_next;
                    Wt_data  <= {27'b0, idx_next};
                    R_addr_A <= 5'd0;
                    R_addr_B <= 5'd0;
                end
                RD1: begin
                    R_addr_A <= idx_next;
                    R_addr_B <= ~idx_next;
                end
                RD2: begin
                    R_addr_A <= idx_next;
                    R_addr_B <= idx_next;
                end
                default: begin
                    Wt_addr  <= 5'd0;
                    Wt_data  <= 32'h0;
                    R_addr_A <= 5'd0;
                    R_addr_B <= 5'd0;
                end
            endcase

            if ((state == IDLE) && start) begin
                err_count <= 8'd0;
                pass      <= 1'b0;
                fail_addr <= 5'd0;
                fail_port <= 1'b0;
            end else if (in_read) begin
                err_count <= err_next;
                if ((err_count == 8'd0) && (miss_a || miss_b)) begin
                    fail_addr <= miss_a ? idx : addr_b;
                    fail_port <= !miss_a;
                end
                if ((state == RD2) && (idx == 5'd31))
                    pass <= (err_next == 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_regs_bist.sv
// Directed bench for regs_bist: two DUTs (ZERO_REG=1 and 0) each beside a
// behavioural register file with hardwired r0; dut1's file can plant a stuck bit.
module tb_regs_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start0;

    logic        ls1, busy1, done1, pass1, fp1;
    logic [4:0]  wa1, ra1, rb1, fa1;
    logic [31:0] wd1, rda1, rdb1;
    logic [7:0]  err1;

    logic        ls0, busy0, done0, pass0, fp0;
    logic [4:0]  wa0, ra0, rb0, fa0;
    logic [31:0] wd0, rda0, rdb0;
    logic [7:0]  err0;

    logic [31:0] mem1 [32];
    logic [31:0] mem0 [32];
    bit          stuck = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int dc;

    always #5 clk = ~clk;

    regs_bist #(.SEED(32'hA5A5A5A5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .rdata_A(rda1), .rdata_B(rdb1),
        .L_S(ls1), .Wt_addr(wa1), .Wt_data(wd1), .R_addr_A(ra1), .R_addr_B(rb1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_addr(fa1), .fail_port(fp1)
    );

    regs_bist #(.SEED(32'hA5A5A5A5), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .rdata_A(rda0), .rdata_B(rdb0),
        .L_S(ls0), .Wt_addr(wa0), .Wt_data(wd0), .R_addr_A(ra0), .R_addr_B(rb0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_addr(fa0), .fail_port(fp0)
    );

    // Register files: r0 reads zero, optional bit 3 of r7 stuck at one
    always @(posedge clk) begin
        if (ls1 && (wa1 != 5'd0)) mem1[wa1] <= wd1;
        if (ls0 && (wa0 != 5'd0)) mem0[wa0] <= wd0;
    end
    assign rda1 = (ra1 == 5'd0) ? 32'h0 : (mem1[ra1] | ((stuck && ra1 == 5'd7) ? 32'h8 : 32'h0));
    assign rdb1 = (rb1 == 5'd0) ? 32'h0 : (mem1[rb1] | ((stuck && rb1 == 5'd7) ? 32'h8 : 32'h0));
    assign rda0 = (ra0 == 5'd0) ? 32'h0 : mem0[ra0];
    assign rdb0 = (rb0 == 5'd0) ? 32'h0 : mem0[rb0];

    always @(negedge clk) if (done1 === 1'b1) done_count++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic value);
        start = value;
        @(negedge clk);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            mem1[a] = 32'h0;
            mem0[a] = 32'h0;
        end
        rst = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        waitCycles(3);
        checkOutput("rst_L_S", 32'(ls1), 32'd0);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
        checkOutput("rst_done", 32'(done1), 32'd0);
        checkOutput("rst_pass", 32'(pass1), 32'd0);
        checkOutput("rst_err", 32'(err1), 32'd0);
        checkOutput("rst_wdata", wd1, 32'h0);
        rst = 1'b1;
        waitCycles(2);
        checkOutput("idle_busy", 32'(busy1), 32'd0);
        checkOutput("idle_waddr", 32'(wa1), 32'd0);

        $display("[TB] run A: fault-free, full port trace");
        applyStimulus(1'b1);
        start = 1'b0;
        for (int k = 0; k < 128; k++) begin
            checkOutput($sformatf("A_busy_c%0d", k), 32'(busy1), 32'd1);
            checkOutput($sformatf("A_done_c%0d", k), 32'(done1), 32'd0);
            if (k < 32) begin
                checkOutput($sformatf("A_ls_c%0d", k), 32'(ls1), 32'd1);
                checkOutput($sformatf("A_waddr_c%0d", k), 32'(wa1), 32'(k));
                checkOutput($sformatf("A_wdata_c%0d", k), wd1, (k % 2 == 1) ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
            end else if (k < 64) begin
                checkOutput($sformatf("A_ls_c%0d", k), 32'(ls1), 32'd0);
                checkOutput($sformatf("A_raddrA_c%0d", k), 32'(ra1), 32'(k - 32));
                checkOutput($sformatf("A_raddrB_c%0d", k), 32'(rb1), 32'(31 - (k - 32)));
                checkOutput($sformatf("A_hold_c%0d", k), wd1, 32'hA5A5A5A5);
            end else if (k < 96) begin
                checkOutput($sformatf("A_ls_c%0d", k), 32'(ls1), 32'd1);
                checkOutput($sformatf("A_waddr_c%0d", k), 32'(wa1), 32'(k - 64));
                checkOutput($sformatf("A_wdata_c%0d", k), wd1, 32'(k - 64));
            end else begin
                checkOutput($sformatf("A_ls_c%0d", k), 32'(ls1), 32'd0);
                checkOutput($sformatf("A_raddrA_c%0d", k), 32'(ra1), 32'(k - 96));
                checkOutput($sformatf("A_raddrB_c%0d", k), 32'(rb1), 32'(k - 96));
                checkOutput($sformatf("A_hold_c%0d", k), wd1, 32'd31);
            end
            @(negedge clk);
        end
        checkOutput("A_fin_done", 32'(done1), 32'd1);
        checkOutput("A_fin_busy", 32'(busy1), 32'd0);
        checkOutput("A_fin_pass", 32'(pass1), 32'd1);
        checkOutput("A_fin_err", 32'(err1), 32'd0);
        waitCycles(1);
        checkOutput("A_after_done", 32'(done1), 32'd0);
        checkOutput("A_held_pass", 32'(pass1), 32'd1);
        checkOutput("A_done_count", 32'(done_count), 32'd1);

        $display("[TB] run B: r7 bit 3 stuck at one");
        stuck = 1'b1;
        waitCycles(2);
        applyStimulus(1'b1);
        start = 1'b0;
        checkOutput("B_pass_cleared", 32'(pass1), 32'd0);
        waitCycles(64);
        checkOutput("B_err_after_rd1", 32'(err1), 32'd2);
        checkOutput("B_faddr_after_rd1", 32'(fa1), 32'd7);
        checkOutput("B_fport_after_rd1", 32'(fp1), 32'd0);
        waitCycles(39);
        checkOutput("B_err_c103", 32'(err1), 32'd2);
        waitCycles(1);
        checkOutput("B_err_c104", 32'(err1), 32'd4);
        waitCycles(24);
        checkOutput("B_fin_done", 32'(done1), 32'd1);
        checkOutput("B_fin_err", 32'(err1), 32'd4);
        checkOutput("B_fin_faddr", 32'(fa1), 32'd7);
        checkOutput("B_fin_fport", 32'(fp1), 32'd0);
        checkOutput("B_fin_pass", 32'(pass1), 32'd0);
        stuck = 1'b0;

        $display("[TB] run C: second start at E+50 ignored");
        waitCycles(2);
        dc = done_count;
        applyStimulus(1'b1);
        start = 1'b0;
        checkOutput("C_err_cleared", 32'(err1), 32'd0);
        checkOutput("C_faddr_cleared", 32'(fa1), 32'd0);
        waitCycles(49);
        applyStimulus(1'b1);
        start = 1'b0;
        waitCycles(77);
        checkOutput("C_c127_done", 32'(done1), 32'd0);
        checkOutput("C_c127_busy", 32'(busy1), 32'd1);
        waitCycles(1);
        checkOutput("C_fin_done", 32'(done1), 32'd1);
        checkOutput("C_fin_pass", 32'(pass1), 32'd1);
        waitCycles(1);
        checkOutput("C_idle_busy", 32'(busy1), 32'd0);
        waitCycles(130);
        checkOutput("C_done_once", 32'(done_count - dc), 32'd1);
        checkOutput("C_no_restart", 32'(busy1), 32'd0);

        $display("[TB] run D: reset aborts mid-run");
        dc = done_count;
        applyStimulus(1'b1);
        start = 1'b0;
        waitCycles(10);
        rst = 1'b0;
        #1;
        checkOutput("D1_ls_async", 32'(ls1), 32'd0);
        checkOutput("D1_busy_async", 32'(busy1), 32'd0);
        waitCycles(2);
        rst = 1'b1;
        waitCycles(2);
        applyStimulus(1'b1);
        start = 1'b0;
        waitCycles(40);
        checkOutput("D2_busy_before", 32'(busy1), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("D2_busy_async", 32'(busy1), 32'd0);
        checkOutput("D2_ls_async", 32'(ls1), 32'd0);
        checkOutput("D2_err_async", 32'(err1), 32'd0);
        waitCycles(2);
        rst = 1'b1;
        waitCycles(130);
        checkOutput("D_no_done", 32'(done_count - dc), 32'd0);
        applyStimulus(1'b1);
        start = 1'b0;
        waitCycles(128);
        checkOutput("D_fresh_done", 32'(done1), 32'd1);
        checkOutput("D_fresh_pass", 32'(pass1), 32'd1);
        checkOutput("D_fresh_err", 32'(err1), 32'd0);

        $display("[TB] run E: ZERO_REG=0 against hardwired r0");
        waitCycles(2);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("E_busy", 32'(busy0), 32'd1);
        waitCycles(128);
        checkOutput("E_done", 32'(done0), 32'd1);
        checkOutput("E_err", 32'(err0), 32'd2);
        checkOutput("E_faddr", 32'(fa0), 32'd0);
        checkOutput("E_fport", 32'(fp0), 32'd0);
        checkOutput("E_pass", 32'(pass0), 32'd0);

        $display("[TB] run F: start held high, back-to-back runs");
        waitCycles(2);
        applyStimulus(1'b1);
        waitCycles(128);
        checkOutput("F_fin_done", 32'(done1), 32'd1);
        waitCycles(1);
        checkOutput("F_idle_busy", 32'(busy1), 32'd0);
        checkOutput("F_idle_done", 32'(done1), 32'd0);
        waitCycles(1);
        start = 1'b0;
        checkOutput("F_restart_busy", 32'(busy1), 32'd1);
        checkOutput("F_restart_ls", 32'(ls1), 32'd1);
        checkOutput("F_restart_pass", 32'(pass1), 32'd0);
        waitCycles(128);
        checkOutput("F2_fin_done", 32'(done1), 32'd1);
        checkOutput("F2_fin_pass", 32'(pass1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
